// File: rtl/branch_resolve_stage_pkg.sv
// Shared CPU definitions: branch type encodings and branch FSM states.
// Also holds the branch-taken rule so the decoder and EX agree on it.
package branch_resolve_stage_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  localparam int FCNT_W = 3;

  function automatic logic br_taken(
    input logic [1:0] br_type,
    input logic       nonzero
  );
    logic t;
    t = 1'b0;
    unique case (br_type_e'(br_type))
      BR_NONE: t = 1'b0;
      BR_BEQ:  t = !nonzero;
      BR_BNE:  t = nonzero;
      BR_JMP:  t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_stage_flush_counter.sv
// Down-counter with load, enable and zero flag.
// Tracks the remaining flush cycles for the branch FSM.
module branch_resolve_stage_flush_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (dec_i && cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/branch_resolve_stage.sv
// Branch resolution: PC redirect pulse, multi-cycle flush and
// a saturating taken-branch counter, all outputs registered.
module branch_resolve_stage
  import branch_resolve_stage_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        br_type_i,
  input  logic              nonzero_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              stall_i,
  output logic              pc_src_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD =
    FCNT_W'(FLUSH_CYCLES - 1);

  br_state_e         state_q, state_d;
  logic              pc_src_q, pc_src_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic taken;

  assign taken = br_taken(br_type_i, nonzero_i);

  always_comb begin
    state_d     = state_q;
    pc_src_d    = pc_src_q;
    pc_target_d = pc_target_q;
    flush_d     = flush_q;
    taken_cnt_d = taken_cnt_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    if (!stall_i) begin
      unique case (state_q)
        ST_IDLE: begin
          pc_src_d = 1'b0;
          flush_d  = 1'b0;
          if (valid_i && taken) begin
            pc_src_d    = 1'b1;
            pc_target_d = target_i;
            flush_d     = 1'b1;
            cnt_load    = 1'b1;
            state_d     = ST_FLUSH;
            if (taken_cnt_q != '1) begin
              taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
          end
        end
        // wrong-path instructions are ignored here
        ST_FLUSH: begin
          pc_src_d = 1'b0;
          if (cnt_zero) begin
            state_d = ST_IDLE;
            flush_d = 1'b0;
          end else begin
            cnt_dec = 1'b1;
            flush_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
      flush_q     <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_src_q    <= pc_src_d;
      pc_target_q <= pc_target_d;
      flush_q     <= flush_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  branch_resolve_stage_flush_counter #(
    .W(FCNT_W)
  ) u_flush_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (!stall_i),
    .load_i     (cnt_load),
    .load_val_i (FLUSH_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign pc_src_o    = pc_src_q;
  assign pc_target_o = pc_target_q;
  assign flush_o     = flush_q;
  assign busy_o      = (state_q == ST_FLUSH);
  assign taken_cnt_o = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Bench for branch_resolve_stage: directed scenarios plus
// random traffic against a remaining-flush-cycles model.
module tb_branch_resolve_stage;

  localparam int AW = 32;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] BEQ  = 2'b01;
  localparam logic [1:0] BNE  = 2'b10;
  localparam logic [1:0] JMP  = 2'b11;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [1:0]    br_type_i;
  logic          nonzero_i;
  logic [AW-1:0] target_i;
  logic          stall_i;
  logic          pc_src_o;
  logic [AW-1:0] pc_target_o;
  logic          flush_o;
  logic          busy_o;
  logic [CW-1:0] taken_cnt_o;

  int errors = 0;
  int checks = 0;

  // model: remaining flush cycles instead of an FSM
  logic          m_pc_src;
  logic [AW-1:0] m_target;
  int            m_rem;
  int            m_cnt;

  branch_resolve_stage #(
    .ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .br_type_i   (br_type_i),
    .nonzero_i   (nonzero_i),
    .target_i    (target_i),
    .stall_i     (stall_i),
    .pc_src_o    (pc_src_o),
    .pc_target_o (pc_target_o),
    .flush_o     (flush_o),
    .busy_o      (busy_o),
    .taken_cnt_o (taken_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit is_taken(logic [1:0] t, logic nz);
    return (t == BEQ && !nz) || (t == BNE && nz) || (t == JMP);
  endfunction

  task automatic model_reset();
    m_pc_src = 1'b0;
    m_target = '0;
    m_rem    = 0;
    m_cnt    = 0;
  endtask

  task automatic drv(input logic v, input logic [1:0] t,
                     input logic nz, input logic [AW-1:0] tg,
                     input logic st);
    valid_i   = v;
    br_type_i = t;
    nonzero_i = nz;
    target_i  = tg;
    stall_i   = st;
  endtask

  task automatic idle();
    drv(1'b0, NONE, 1'b0, '0, 1'b0);
  endtask

  // one clock edge: advance model with pre-edge inputs
  task automatic tick();
    @(posedge clk_i);
    if (!stall_i) begin
      if (m_rem > 0) begin
        m_rem--;
        m_pc_src = 1'b0;
      end else if (valid_i && is_taken(br_type_i, nonzero_i)) begin
        m_pc_src = 1'b1;
        m_target = target_i;
        m_rem    = FC;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_pc_src = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle();
    model_reset();
    #3;
    checks++;
    if ({pc_src_o, flush_o, busy_o} !== 3'b000 ||
        pc_target_o !== '0 || taken_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset: src=%b tgt=%h fl=%b busy=%b cnt=%0d want 0",
               pc_src_o, pc_target_o, flush_o, busy_o, taken_cnt_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_beq_taken(input string tag);
    drv(1'b1, BEQ, 1'b0, 32'h0000_0040, 1'b0);
    tick();
    idle();
    checks++;
    if (pc_src_o !== 1'b1 || pc_target_o !== 32'h40 ||
        flush_o !== 1'b1 || taken_cnt_o !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL %s_redirect: src=%b tgt=%h fl=%b cnt=%0d want 1 40 1 %0d",
               tag, pc_src_o, pc_target_o, flush_o, taken_cnt_o, m_cnt);
    end
    tick();
    checks++;
    if (pc_src_o !== 1'b0 || flush_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_flush2: src=%b fl=%b busy=%b want 0 1 1",
               tag, pc_src_o, flush_o, busy_o);
    end
    tick();
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_flush_end: fl=%b busy=%b want 0 0",
               tag, flush_o, busy_o);
    end
  endtask

  task automatic test_not_taken();
    logic [1:0] ty [3];
    logic       nz [3];
    ty = '{BNE, BEQ, NONE};
    nz = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, ty[i], nz[i], 32'h0000_0500 + i, 1'b0);
      tick();
      checks++;
      if (pc_src_o !== 1'b0 || flush_o !== 1'b0 ||
          taken_cnt_o !== CW'(m_cnt) || pc_target_o !== m_target) begin
        errors++;
        $display("FAIL not_taken%0d: src=%b fl=%b cnt=%0d tgt=%h want 0 0 %0d %h",
                 i, pc_src_o, flush_o, taken_cnt_o, pc_target_o,
                 m_cnt, m_target);
      end
    end
    idle();
  endtask

  task automatic test_jmp_during_flush();
    int c0;
    c0 = m_cnt;
    drv(1'b1, JMP, 1'b0, 32'h0000_0100, 1'b0);
    tick();
    drv(1'b1, JMP, 1'b0, 32'h0000_0200, 1'b0);
    tick();
    idle();
    checks++;
    if (pc_target_o !== 32'h100 || pc_src_o !== 1'b0) begin
      errors++;
      $display("FAIL jmp_in_flush: tgt=%h src=%b want 100 0",
               pc_target_o, pc_src_o);
    end
    repeat (2) tick();
    checks++;
    if (taken_cnt_o !== CW'(c0 + 1) || pc_target_o !== 32'h100) begin
      errors++;
      $display("FAIL jmp_in_flush_cnt: cnt=%0d tgt=%h want %0d 100",
               taken_cnt_o, pc_target_o, c0 + 1);
    end
  endtask

  task automatic test_stall();
    int fl_cycles;
    drv(1'b1, BEQ, 1'b0, 32'h0000_0abc, 1'b0);
    tick();
    drv(1'b1, JMP, 1'b0, 32'h0000_0def, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_src_o !== 1'b1 || flush_o !== 1'b1 ||
          pc_target_o !== 32'habc) begin
        errors++;
        $display("FAIL stall_hold%0d: src=%b fl=%b tgt=%h want 1 1 abc",
                 i, pc_src_o, flush_o, pc_target_o);
      end
    end
    // count unstalled flush cycles from the redirect onward
    fl_cycles = 1;
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (flush_o === 1'b1) fl_cycles++;
      if (i == 0) begin
        checks++;
        if (pc_src_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_release: src=%b want 0", pc_src_o);
        end
      end
    end
    checks++;
    if (fl_cycles != FC) begin
      errors++;
      $display("FAIL stall_flush_len: cycles=%0d want %0d", fl_cycles, FC);
    end
  endtask

  task automatic test_async_reset();
    drv(1'b1, JMP, 1'b0, 32'h0000_0300, 1'b0);
    tick();
    idle();
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pc_src_o, flush_o, busy_o} !== 3'b000 ||
        pc_target_o !== '0 || taken_cnt_o !== '0) begin
      errors++;
      $display("FAIL async_reset: src=%b tgt=%h fl=%b busy=%b cnt=%0d want 0",
               pc_src_o, pc_target_o, flush_o, busy_o, taken_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    test_beq_taken("after_rst");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drv(1'b1, JMP, 1'b0, AW'(32'h1000 + 4 * i), 1'b0);
      tick();
      idle();
      repeat (3) tick();
    end
    checks++;
    if (taken_cnt_o !== CW'(CMAX) || m_cnt != CMAX) begin
      errors++;
      $display("FAIL saturate: cnt=%0d want %0d", taken_cnt_o, CMAX);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), AW'($urandom),
          $urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (pc_src_o !== m_pc_src || pc_target_o !== m_target ||
          flush_o !== (m_rem > 0) || busy_o !== (m_rem > 0) ||
          taken_cnt_o !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL random%0d: src=%b tgt=%h fl=%b busy=%b cnt=%0d want %b %h %b %b %0d",
                 i, pc_src_o, pc_target_o, flush_o, busy_o, taken_cnt_o,
                 m_pc_src, m_target, m_rem > 0, m_rem > 0, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_beq_taken("beq");
    test_not_taken();
    test_jmp_during_flush();
    test_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
